// File: rtl/unified_memory_pkg.sv
// Shared definitions for the unified instruction/data memory.
// Holds default widths, the init/run state encoding and the boot image
// loaded into the low words at reset.
package unified_memory_pkg;

  localparam int unsigned DSIZE_DEF = 32;
  localparam int unsigned ISIZE_DEF = 32;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned NBOOT_MAX = 9;

  localparam logic [31:0] BOOT_IMAGE [NBOOT_MAX] = '{
    32'h0000_0000, 32'h0503_1000, 32'h0043_0800, 32'h0901_F000, 32'h1502_F800,
    32'h03FA_5000, 32'h18E4_0001, 32'h0000_0000, 32'h0000_0000
  };

  // Boot word for a given index; zero past the end of the table.
  function automatic logic [31:0] boot_word(input logic [31:0] idx);
    logic [31:0] w;
    w = '0;
    for (int unsigned k = 0; k < NBOOT_MAX; k++) begin
      if (idx == k) w = BOOT_IMAGE[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/unified_memory_init_seq.sv
// Reset-time init sequencer for unified_memory.
// Walks every word address once, writing the boot image into the first
// NBOOT words and zero into the rest, then moves to RUN and raises ready.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   init_we     array write strobe while initialising
//   init_addr   word index being initialised
//   init_data   word value being written
//   ready       high once every word has been initialised
module unified_memory_init_seq
  import unified_memory_pkg::*;
#(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned NBOOT = 9,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_we,
  output logic [AW-1:0]    init_addr,
  output logic [DSIZE-1:0] init_data,
  output logic             ready
);

  state_e        st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= StInit;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    init_we   = 1'b0;
    init_addr = cnt_q;
    init_data = '0;
    unique case (st_q)
      StInit: begin
        init_we = 1'b1;
        if (32'(cnt_q) < NBOOT) init_data = DSIZE'(boot_word(32'(cnt_q)));
        if (cnt_q == AW'(DEPTH - 1)) begin
          st_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: ;
      default: st_d = StInit;
    endcase
  end

  assign ready = (st_q == StRun);

endmodule

// File: rtl/unified_memory.sv
// Dual-port word memory: port I is a read-only fetch port, port D is a
// read/write data port with byte enables. Both ports answer one cycle after
// an accepted request; out-of-range requests return zero with an error pulse.
// Requests are ignored until the init sequencer has filled the array.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   ready                        init complete, requests accepted
//   i_en, i_addr                 instruction read request
//   i_data, i_valid, i_err       instruction response
//   d_en, d_wen, d_be, d_addr,
//   d_wdata                      data request (read or byte-enabled write)
//   d_rdata, d_valid, d_err      data response
module unified_memory
  import unified_memory_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned ISIZE = ISIZE_DEF,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned NBOOT = 9
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               i_en,
  input  logic [ISIZE-1:0]   i_addr,
  output logic [DSIZE-1:0]   i_data,
  output logic               i_valid,
  output logic               i_err,
  input  logic               d_en,
  input  logic               d_wen,
  input  logic [DSIZE/8-1:0] d_be,
  input  logic [ISIZE-1:0]   d_addr,
  input  logic [DSIZE-1:0]   d_wdata,
  output logic [DSIZE-1:0]   d_rdata,
  output logic               d_valid,
  output logic               d_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NB = DSIZE / 8;

  logic [DSIZE-1:0] mem [DEPTH];

  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [DSIZE-1:0] init_data;

  unified_memory_init_seq #(
    .DSIZE(DSIZE),
    .DEPTH(DEPTH),
    .NBOOT(NBOOT),
    .AW   (AW)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .ready    (ready)
  );

  // Full-width compare so high address bits never alias into the array.
  logic          i_hit, d_hit;
  logic [AW-1:0] i_idx, d_idx;
  logic          i_acc, d_acc, d_wr;

  assign i_hit = (i_addr < ISIZE'(DEPTH));
  assign d_hit = (d_addr < ISIZE'(DEPTH));
  assign i_idx = i_addr[AW-1:0];
  assign d_idx = d_addr[AW-1:0];
  assign i_acc = ready & i_en;
  assign d_acc = ready & d_en;
  assign d_wr  = d_acc & d_wen & d_hit;

  // Array has no reset; the init sequencer owns it until ready.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (d_wr) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (d_be[k]) mem[d_idx][8*k +: 8] <= d_wdata[8*k +: 8];
      end
    end
  end

  logic [DSIZE-1:0] i_data_q, d_rdata_q;
  logic             i_valid_q, i_err_q, d_valid_q, d_err_q;

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_data_q  <= '0;
      i_valid_q <= 1'b0;
      i_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_valid_q <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      i_valid_q <= i_acc;
      i_err_q   <= i_acc & ~i_hit;
      if (i_acc) i_data_q <= i_hit ? mem[i_idx] : '0;
      d_valid_q <= d_acc & ~d_wen;
      d_err_q   <= d_acc & ~d_hit;
      if (d_acc & ~d_wen) d_rdata_q <= d_hit ? mem[d_idx] : '0;
    end
  end

  assign i_data  = i_data_q;
  assign i_valid = i_valid_q;
  assign i_err   = i_err_q;
  assign d_rdata = d_rdata_q;
  assign d_valid = d_valid_q;
  assign d_err   = d_err_q;

endmodule

// File: tb/tb_unified_memory.sv
module tb_unified_memory;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        i_en;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_valid, i_err;
  logic        d_en, d_wen;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_err;

  unified_memory #(
    .DSIZE(32),
    .ISIZE(32),
    .DEPTH(DEPTH),
    .NBOOT(9)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ready  (ready),
    .i_en   (i_en),
    .i_addr (i_addr),
    .i_data (i_data),
    .i_valid(i_valid),
    .i_err  (i_err),
    .d_en   (d_en),
    .d_wen  (d_wen),
    .d_be   (d_be),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .d_err  (d_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        qi[$];
  exp_t        qd[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_i, last_d;
  bit          run;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents right after a completed init.
  task automatic model_init();
    logic [31:0] boot [9];
    boot = '{32'h00000000, 32'h05031000, 32'h00430800, 32'h0901F000, 32'h1502F800,
             32'h03fa5000, 32'h18E40001, 32'h00000000, 32'h00000000};
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = (a < 9) ? boot[a] : 32'h0;
  endtask

  // One request cycle, driven at the falling edge; expectations are queued
  // using the pre-edge memory image, then the model applies the write.
  task automatic issue(input bit ie, input logic [31:0] ia, input bit de, input bit dw,
                       input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
    exp_t e;
    logic [31:0] mask;
    @(negedge clk);
    i_en = ie; i_addr = ia; d_en = de; d_wen = dw; d_be = be; d_addr = da; d_wdata = wd;
    if (!run) return;
    if (ie) begin
      e.valid = 1'b1;
      e.err   = (ia >= DEPTH);
      e.data  = e.err ? 32'h0 : ref_mem[ia[7:0]];
      qi.push_back(e);
    end
    if (de && !dw) begin
      e.valid = 1'b1;
      e.err   = (da >= DEPTH);
      e.data  = e.err ? 32'h0 : ref_mem[da[7:0]];
      qd.push_back(e);
    end
    if (de && dw) begin
      if (da >= DEPTH) begin
        e.valid = 1'b0;
        e.err   = 1'b1;
        e.data  = 32'h0;
        qd.push_back(e);
      end else begin
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        ref_mem[da[7:0]] = (ref_mem[da[7:0]] & ~mask) | (wd & mask);
      end
    end
  endtask

  task automatic idle();
    issue(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  // Release reset and count cycles until ready, with junk requests driven.
  task automatic release_and_wait();
    int n;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!ready && n < 2 * DEPTH) begin
      @(negedge clk);
      n++;
      if (!ready) begin
        i_en = 1'b1; i_addr = $urandom_range(0, DEPTH - 1);
        d_en = 1'b1; d_wen = $urandom_range(0, 1); d_be = 4'hF;
        d_addr = $urandom_range(0, DEPTH - 1); d_wdata = $urandom;
      end
    end
    chk("init_cycles", n, DEPTH);
    i_en = 1'b0; d_en = 1'b0; d_wen = 1'b0;
    model_init();
    run = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    run = 1'b0;
    rst = 1'b1;
    qi.delete();
    qd.delete();
    last_i = 32'h0;
    last_d = 32'h0;
  endtask

  // Monitor: pops one expectation per response; otherwise outputs must be
  // idle and data must hold.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (qi.size() > 0) begin
      e = qi.pop_front();
      chk("i_valid", {31'b0, i_valid}, 32'd1);
      chk("i_err", {31'b0, i_err}, {31'b0, e.err});
      chk("i_data", i_data, e.data);
      last_i = e.data;
    end else begin
      chk("i_idle", {30'b0, i_valid, i_err}, 32'd0);
      chk("i_hold", i_data, last_i);
    end
    if (qd.size() > 0) begin
      e = qd.pop_front();
      chk("d_valid", {31'b0, d_valid}, {31'b0, e.valid});
      chk("d_err", {31'b0, d_err}, {31'b0, e.err});
      if (e.valid) begin
        chk("d_rdata", d_rdata, e.data);
        last_d = e.data;
      end else begin
        chk("d_rdata_hold", d_rdata, last_d);
      end
    end else begin
      chk("d_idle", {30'b0, d_valid, d_err}, 32'd0);
      chk("d_hold", d_rdata, last_d);
    end
  end

  initial begin
    logic [31:0] a;
    run = 1'b0;
    last_i = 32'h0; last_d = 32'h0;
    rst = 1'b1;
    i_en = 0; i_addr = 0; d_en = 0; d_wen = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_outs", {28'b0, i_valid, i_err, d_valid, d_err}, 32'd0);

    // Reset mid-init at cnt=100, then a full init from scratch.
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midinit_ready", {31'b0, ready}, 32'd0);
    release_and_wait();

    // Boot image reads.
    issue(1, 32'd1, 0, 0, 4'h0, 0, 0);
    issue(1, 32'd6, 0, 0, 4'h0, 0, 0);
    issue(1, 32'd200, 0, 0, 4'h0, 0, 0);
    idle();
    issue(1, 32'd3, 0, 0, 4'h0, 0, 0);
    idle();
    // Partial byte-enable write then read back.
    issue(0, 0, 1, 1, 4'b0101, 32'd20, 32'hAABBCCDD);
    issue(0, 0, 1, 0, 4'h0, 32'd20, 32'h0);
    // Same-cycle write on D and read on I: old data, then new data.
    issue(1, 32'd5, 1, 1, 4'hF, 32'd5, 32'h12345678);
    issue(1, 32'd5, 0, 0, 4'h0, 0, 0);
    // Out-of-range reads and write; aliasing write to 300 must not touch 44.
    issue(1, 32'hFFFFFFFF, 1, 0, 4'h0, 32'd256, 0);
    issue(0, 0, 1, 1, 4'hF, 32'd300, 32'hDEADBEEF);
    issue(0, 0, 1, 1, 4'h0, 32'd7, 32'hFFFFFFFF);
    idle();
    for (int i = 0; i < DEPTH; i++) issue(1, i, 1, 0, 4'h0, DEPTH - 1 - i, 0);

    // Random mixed traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ia, da;
      int r;
      r = $urandom_range(0, 9);
      ia = (r == 0) ? $urandom : (r == 1) ? DEPTH + $urandom_range(0, 40)
                                          : $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      da = (r == 0) ? $urandom : (r == 1) ? DEPTH + $urandom_range(0, 40)
                                          : $urandom_range(0, 15);
      issue($urandom_range(0, 1), ia, $urandom_range(0, 1), $urandom_range(0, 1),
            4'($urandom), da, $urandom);
    end
    idle();

    // Reset mid-run: memory must come back to the boot image.
    do_reset();
    @(negedge clk);
    chk("midrun_ready", {31'b0, ready}, 32'd0);
    release_and_wait();
    for (int i = 0; i < 24; i++) begin
      a = i;
      issue(1, a, 1, 0, 4'h0, a, 0);
    end
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
